// File: rtl/stage_execute_md_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
// Contents: MD_OP_* operation codes, MD_STATE_* sequencer states and small
// classification helpers used by the sequencer.
package stage_execute_md_pkg;

    typedef enum logic [2:0] {
        MD_OP_NONE  = 3'd0,
        MD_OP_MULT  = 3'd1,
        MD_OP_MULTU = 3'd2,
        MD_OP_DIV   = 3'd3,
        MD_OP_DIVU  = 3'd4,
        MD_OP_MTHI  = 3'd5,
        MD_OP_MTLO  = 3'd6
    } md_op_t;

    typedef enum logic {
        MD_STATE_IDLE = 1'b0,
        MD_STATE_RUN  = 1'b1
    } md_state_t;

    // True for operations that occupy the unit for a multi-cycle busy period.
    function automatic logic md_is_start(input logic [2:0] op);
        return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
               (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

endpackage

// File: rtl/stage_execute_md_compute.sv
// md_compute: purely combinational multiply/divide datapath.
// Ports:
//   md_op  in  3   operation code (MD_OP_*)
//   in0    in  32  rs operand
//   in1    in  32  rt operand
//   result out 64  {hi, lo} for the operation
//   wr_en  out 1   result is to be committed (0 on divide by zero / non-arith op)
module md_compute
    import stage_execute_md_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    output logic [63:0] result,
    output logic        wr_en
);

    logic [31:0] divisor;
    logic [31:0] quo;
    logic [31:0] rem;

    always_comb begin
        result  = '0;
        wr_en   = 1'b0;
        quo     = '0;
        rem     = '0;
        // Substitute 1 for a zero divisor so the divider never sees 0; the
        // result is discarded through wr_en anyway.
        divisor = (in1 == '0) ? 32'd1 : in1;
        case (md_op_t'(md_op))
            MD_OP_MULT: begin
                result = $signed({{32{in0[31]}}, in0}) * $signed({{32{in1[31]}}, in1});
                wr_en  = 1'b1;
            end
            MD_OP_MULTU: begin
                result = {32'd0, in0} * {32'd0, in1};
                wr_en  = 1'b1;
            end
            MD_OP_DIV: begin
                // 0x80000000 / -1 overflows 32 bits; pin the architectural result.
                if (in0 == 32'h8000_0000 && in1 == 32'hFFFF_FFFF) begin
                    quo = 32'h8000_0000;
                    rem = '0;
                end else begin
                    quo = $signed(in0) / $signed(divisor);
                    rem = $signed(in0) % $signed(divisor);
                end
                result = {rem, quo};
                wr_en  = (in1 != '0);
            end
            MD_OP_DIVU: begin
                quo    = in0 / divisor;
                rem    = in0 % divisor;
                result = {rem, quo};
                wr_en  = (in1 != '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/stage_execute_md.sv
// stage_execute_md: multiply/divide sequencer beside the EX-stage ALU.
// Holds HI/LO, computes a mult/div result in the start cycle, then stays
// busy for a fixed number of cycles before committing it.
// Ports:
//   clk    in  1   system clock
//   reset  in  1   synchronous active-high reset
//   md_op  in  3   MD_OP_* operation code
//   in0    in  32  rs operand (forwarded)
//   in1    in  32  rt operand (forwarded)
//   busy   out 1   unit computing, or accepting a start this cycle
//   hi     out 32  architectural HI
//   lo     out 32  architectural LO
module stage_execute_md
    import stage_execute_md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = ($clog2(CNT_MAX + 1) > 4) ? $clog2(CNT_MAX + 1) : 4;

    md_state_t        state;
    md_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      p_hi;
    logic [31:0]      p_lo;
    logic             p_wr;
    logic             start;
    logic             finish;
    logic [63:0]      md_result;
    logic             md_wr_en;

    assign start  = md_is_start(md_op);
    assign finish = (cnt == CNT_W'(1));

    md_compute u_md_compute (
        .md_op  (md_op),
        .in0    (in0),
        .in1    (in1),
        .result (md_result),
        .wr_en  (md_wr_en)
    );

    // State register plus counter, pending result and HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_STATE_IDLE;
            cnt   <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            p_wr  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                MD_STATE_IDLE: begin
                    if (start) begin
                        {p_hi, p_lo} <= md_result;
                        p_wr         <= md_wr_en;
                        cnt          <= md_is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    end else if (md_op == MD_OP_MTHI) begin
                        hi <= in0;
                    end else if (md_op == MD_OP_MTLO) begin
                        lo <= in0;
                    end
                end
                MD_STATE_RUN: begin
                    // Any md_op arriving here is ignored.
                    cnt <= cnt - CNT_W'(1);
                    if (finish && p_wr) begin
                        hi <= p_hi;
                        lo <= p_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_STATE_IDLE: if (start)  state_nxt = MD_STATE_RUN;
            MD_STATE_RUN:  if (finish) state_nxt = MD_STATE_IDLE;
            default:       state_nxt = MD_STATE_IDLE;
        endcase
    end

    // busy is combinational in the start cycle so ID stalls in that same cycle.
    always_comb begin
        busy = (state == MD_STATE_RUN) || ((state == MD_STATE_IDLE) && start);
    end

endmodule

// File: tb/tb_stage_execute_md.sv
module tb_stage_execute_md;
    import stage_execute_md_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic [2:0]  md_op;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    stage_execute_md #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md_op (md_op),
        .in0   (in0),
        .in1   (in1),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        busy;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic done   = 1'b0;

    // Reference model: architectural HI/LO, the cycle the unit stops being
    // busy, and a result scheduled to appear at a future cycle.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          busy_end = -1;
    logic [63:0] pend = '0;
    logic        pend_valid = 1'b0;
    int          pend_cycle = 0;

    task automatic ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              output logic [63:0] r, output logic wr);
        longint          sa, sb_, q, rm;
        longint unsigned ua, ub;
        sa = {{32{a[31]}}, a};
        sb_ = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        wr = 1'b1;
        case (op)
            MD_OP_MULT:  r = sa * sb_;
            MD_OP_MULTU: r = ua * ub;
            MD_OP_DIV: begin
                if (b == 0) wr = 1'b0;
                else begin
                    q  = sa / sb_;
                    rm = sa % sb_;
                    r  = {rm[31:0], q[31:0]};
                end
            end
            MD_OP_DIVU: begin
                if (b == 0) wr = 1'b0;
                else r = {32'(ua % ub), 32'(ua / ub)};
            end
            default: wr = 1'b0;
        endcase
    endtask

    task automatic step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic rst);
        logic [63:0] r;
        logic        wr;
        logic        in_run;
        logic        is_start;
        int          n;
        exp_t        e;
        @(posedge clk);
        #1;
        md_op = op;
        in0   = a;
        in1   = b;
        reset = rst;
        if (pend_valid && cyc >= pend_cycle) begin
            m_hi = pend[63:32];
            m_lo = pend[31:0];
            pend_valid = 1'b0;
        end
        in_run   = (cyc <= busy_end);
        is_start = (op >= MD_OP_MULT) && (op <= MD_OP_DIVU);
        e.cyc  = cyc;
        e.busy = in_run || is_start;
        e.hi   = m_hi;
        e.lo   = m_lo;
        sb.push_back(e);
        if (rst) begin
            m_hi = '0;
            m_lo = '0;
            pend_valid = 1'b0;
            busy_end = -1;
        end else if (!in_run) begin
            if (is_start) begin
                n = (op == MD_OP_DIV || op == MD_OP_DIVU) ? DC : MC;
                busy_end = cyc + n;
                ref_result(op, a, b, r, wr);
                if (wr) begin
                    pend = r;
                    pend_valid = 1'b1;
                    pend_cycle = cyc + n + 1;
                end
            end else if (op == MD_OP_MTHI) begin
                m_hi = a;
            end else if (op == MD_OP_MTLO) begin
                m_lo = a;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(MD_OP_NONE, $urandom, $urandom, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input int c, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, got, want);
        end
    endtask

    // Monitor: compares the DUT against every expectation queued for this cycle.
    exp_t m_e;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            m_e = sb.pop_front();
            check("busy", m_e.cyc, {31'd0, busy}, {31'd0, m_e.busy});
            check("hi",   m_e.cyc, hi, m_e.hi);
            check("lo",   m_e.cyc, lo, m_e.lo);
        end
        if (done) begin
            check("scoreboard_drained", cyc, 32'(sb.size()), 32'd0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        reset = 1'b1;
        md_op = MD_OP_NONE;
        in0   = '0;
        in1   = '0;
        repeat (3) @(posedge clk);

        // Reset state
        step(MD_OP_NONE, 0, 0, 1'b1);
        idle(2);

        // MULT / MULTU of -2 * 3
        step(MD_OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle(7);
        step(MD_OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle(7);

        // DIV -7/2, then DIVU by zero leaves HI/LO untouched
        step(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(12);
        step(MD_OP_MTHI, 32'h11, 0, 1'b0);
        step(MD_OP_MTLO, 32'h22, 0, 1'b0);
        step(MD_OP_DIVU, 32'd7, 32'd0, 1'b0);
        idle(12);

        // Signed overflow
        step(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(12);

        // MTHI in IDLE, then MTLO during a MULT is ignored
        step(MD_OP_MTHI, 32'h1234, 0, 1'b0);
        step(MD_OP_MULT, 32'd5, 32'd7, 1'b0);
        step(MD_OP_MTLO, 32'hDEAD, 0, 1'b0);
        idle(6);

        // Back-to-back: DIV starts in the first non-busy cycle after a MULT
        step(MD_OP_MULT, 32'd3, 32'd4, 1'b0);
        idle(5);
        step(MD_OP_DIV, 32'd100, 32'd7, 1'b0);
        idle(12);

        // Reset at t+3 of a DIV, then reset together with a start
        step(MD_OP_DIV, 32'd100, 32'd9, 1'b0);
        idle(2);
        step(MD_OP_NONE, 0, 0, 1'b1);
        idle(14);
        step(MD_OP_MULT, 32'd6, 32'd6, 1'b1);
        idle(8);

        // Random traffic, including ops issued while busy and occasional resets
        for (int i = 0; i < 700; i++) begin
            step(3'($urandom_range(0, 6)), pick(), pick(), ($urandom_range(0, 63) == 0));
        end
        idle(14);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        done = 1'b1;
    end

endmodule
